// File: rtl/bulk_ep_responder.sv
// Bulk endpoint responder: one OUT buffer and one IN buffer of MAX_PACKET_SIZE bytes,
// with DATA0/DATA1 toggle tracking, ACK/NAK handshakes and zero-length packet support.
module bulk_ep_responder #(
  parameter int MAX_PACKET_SIZE = 8,
  parameter bit ZLP_EN          = 1'b1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       configured_i,
  input  logic       token_i,
  input  logic [3:0] pid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_end_i,
  input  logic       rx_crc_ok_i,
  input  logic       rx_toggle_i,
  output logic       hs_valid_o,
  output logic [3:0] hs_pid_o,
  output logic       tx_start_o,
  output logic       tx_toggle_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       tx_last_o,
  input  logic       tx_ready_i,
  input  logic       ack_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o
);
  // state    | meaning
  // IDLE     | waiting for a token
  // OUT_DATA | receiving an OUT data packet
  // IN_DATA  | streaming an IN data packet (or a zero-length packet)
  // IN_WAIT  | IN packet sent, waiting for host ACK
  typedef enum logic [1:0] {S_IDLE, S_OUT_DATA, S_IN_DATA, S_IN_WAIT} state_t;

  localparam int AW = $clog2(MAX_PACKET_SIZE);
  localparam int CW = $clog2(MAX_PACKET_SIZE + 1);
  localparam int RW = $clog2(MAX_PACKET_SIZE + 2);
  localparam logic [CW-1:0] MPS_C = CW'(MAX_PACKET_SIZE);
  localparam logic [RW-1:0] MPS_R = RW'(MAX_PACKET_SIZE);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  state_t state_q, state_d;
  logic [7:0] out_mem [MAX_PACKET_SIZE];
  logic [7:0] in_mem  [MAX_PACKET_SIZE];
  logic [RW-1:0] rx_cnt_q;
  logic [CW-1:0] out_cnt_q, out_rd_q, in_cnt_q, tx_rd_q;
  logic out_full_q, out_busy_q, out_tog_q;
  logic frozen_q, zlp_pend_q, in_tog_q, tx_zlp_q, ready_en_q;
  logic hs_valid_q, tx_start_q;
  logic [3:0] hs_pid_q;

  logic tok_ok, tok_out, tok_in, in_has_data, in_send, tx_fire, tx_final;
  logic ack_take, rx_good, app_wr, out_fire, out_final, rx_wr;

  assign tok_ok      = token_i && (state_q == S_IDLE || state_q == S_IN_WAIT);
  assign tok_out     = tok_ok && (pid_i == PID_OUT);
  assign tok_in      = tok_ok && (pid_i == PID_IN);
  assign in_has_data = (in_cnt_q != '0);
  assign in_send     = in_has_data || zlp_pend_q;
  assign tx_valid_o  = (state_q == S_IN_DATA) && !tx_zlp_q;
  assign tx_fire     = tx_valid_o && tx_ready_i;
  assign tx_final    = (tx_rd_q == in_cnt_q - ONE_C);
  // Any token in IN_WAIT means the host never saw our packet; the ACK is lost.
  assign ack_take    = (state_q == S_IN_WAIT) && ack_i && !tok_ok;
  assign rx_good     = rx_crc_ok_i && (rx_cnt_q <= MPS_R);
  assign in_ready_o  = ready_en_q && configured_i && !frozen_q && !tok_in && (in_cnt_q < MPS_C);
  assign app_wr      = in_valid_i && in_ready_o;
  assign out_fire    = out_full_q && out_ready_i;
  assign out_final   = (out_rd_q == out_cnt_q - ONE_C);
  assign rx_wr       = (state_q == S_OUT_DATA) && rx_valid_i && !out_busy_q && (rx_cnt_q < MPS_R);

  assign hs_valid_o  = hs_valid_q;
  assign hs_pid_o    = hs_pid_q;
  assign tx_start_o  = tx_start_q;
  assign tx_toggle_o = in_tog_q;
  assign tx_last_o   = tx_valid_o && tx_final;
  assign tx_data_o   = tx_valid_o ? in_mem[tx_rd_q[AW-1:0]] : 8'h00;
  assign out_valid_o = out_full_q;
  assign out_data_o  = out_full_q ? out_mem[out_rd_q[AW-1:0]] : 8'h00;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_IN_WAIT: begin
        if (tok_out)                 state_d = S_OUT_DATA;
        else if (tok_in && in_send)  state_d = S_IN_DATA;
        else if (tok_in || ack_take) state_d = S_IDLE;
      end
      S_OUT_DATA: if (rx_end_i) state_d = S_IDLE;
      S_IN_DATA:  if (tx_zlp_q || (tx_fire && tx_final)) state_d = S_IN_WAIT;
      default:    state_d = S_IDLE;
    endcase
    if (!configured_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rx_wr)  out_mem[rx_cnt_q[AW-1:0]] <= rx_data_i;
    if (app_wr) in_mem[in_cnt_q[AW-1:0]]  <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_cnt_q <= '0; out_cnt_q <= '0; out_rd_q <= '0; in_cnt_q <= '0; tx_rd_q <= '0;
      out_full_q <= 1'b0; out_busy_q <= 1'b0; out_tog_q <= 1'b0;
      frozen_q <= 1'b0; zlp_pend_q <= 1'b0; in_tog_q <= 1'b0; tx_zlp_q <= 1'b0;
      ready_en_q <= 1'b0; hs_valid_q <= 1'b0; hs_pid_q <= 4'h0; tx_start_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      hs_valid_q <= 1'b0;
      tx_start_q <= 1'b0;
      if (!configured_i) begin
        rx_cnt_q <= '0; out_cnt_q <= '0; out_rd_q <= '0; in_cnt_q <= '0; tx_rd_q <= '0;
        out_full_q <= 1'b0; out_busy_q <= 1'b0; out_tog_q <= 1'b0;
        frozen_q <= 1'b0; zlp_pend_q <= 1'b0; in_tog_q <= 1'b0; tx_zlp_q <= 1'b0;
        hs_pid_q <= 4'h0;
      end else begin
        if (tok_out) begin
          out_busy_q <= out_full_q;
          rx_cnt_q   <= '0;
        end
        // Count saturates one past the limit so oversize packets stay detectable.
        if (state_q == S_OUT_DATA && rx_valid_i && rx_cnt_q <= MPS_R)
          rx_cnt_q <= rx_cnt_q + RW'(1);
        if (out_fire) begin
          out_rd_q <= out_final ? '0 : out_rd_q + ONE_C;
          if (out_final) out_full_q <= 1'b0;
        end
        if (state_q == S_OUT_DATA && rx_end_i && rx_good) begin
          hs_valid_q <= 1'b1;
          hs_pid_q   <= out_busy_q ? PID_NAK : PID_ACK;
          if (!out_busy_q && rx_toggle_i == out_tog_q) begin
            out_tog_q <= ~out_tog_q;
            out_rd_q  <= '0;
            out_cnt_q <= rx_cnt_q[CW-1:0];
            if (rx_cnt_q != '0) out_full_q <= 1'b1;
          end
        end
        if (app_wr) in_cnt_q <= in_cnt_q + ONE_C;
        if (tok_in) begin
          if (in_send) begin
            frozen_q   <= 1'b1;
            tx_start_q <= 1'b1;
            tx_zlp_q   <= !in_has_data;
            tx_rd_q    <= '0;
          end else begin
            hs_valid_q <= 1'b1;
            hs_pid_q   <= PID_NAK;
          end
        end
        if (tx_fire) tx_rd_q <= tx_final ? '0 : tx_rd_q + ONE_C;
        if (ack_take) begin
          in_tog_q   <= ~in_tog_q;
          in_cnt_q   <= '0;
          frozen_q   <= 1'b0;
          zlp_pend_q <= ZLP_EN && (in_cnt_q == MPS_C);
        end
      end
    end
  end
endmodule

// File: tb/tb_bulk_ep_responder.sv
// Scoreboard bench for bulk_ep_responder: expected handshakes, IN bytes, IN toggles
// and OUT bytes are queued as stimulus is driven and popped as the DUT produces them.
module tb_bulk_ep_responder;
  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] ACK     = 4'b0010;
  localparam logic [3:0] NAK     = 4'b1010;

  logic clk, rstn, configured, token_i, rx_valid_i, rx_end_i, rx_crc_ok_i, rx_toggle_i;
  logic [3:0] pid_i;
  logic [7:0] rx_data_i, in_data_i;
  logic hs_valid_o, tx_start_o, tx_toggle_o, tx_valid_o, tx_last_o, tx_ready_i, ack_i;
  logic [3:0] hs_pid_o;
  logic [7:0] tx_data_o, out_data_o;
  logic out_valid_o, out_ready_i, in_valid_i, in_ready_o;

  int checks = 0, failures = 0;
  logic [3:0] exp_hs[$];
  logic [8:0] exp_tx[$];
  logic       exp_tog[$];
  logic [7:0] exp_out[$];
  logic exp_in_tog = 1'b0, exp_out_tog = 1'b0;
  logic tx_force_low = 1'b0, tx_rand = 1'b0;
  logic [3:0] m_hs; logic m_tog; logic [8:0] m_tx; logic [7:0] m_out;

  bulk_ep_responder #(.MAX_PACKET_SIZE(8), .ZLP_EN(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn), .configured_i(configured), .token_i(token_i), .pid_i(pid_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_end_i(rx_end_i),
    .rx_crc_ok_i(rx_crc_ok_i), .rx_toggle_i(rx_toggle_i),
    .hs_valid_o(hs_valid_o), .hs_pid_o(hs_pid_o), .tx_start_o(tx_start_o),
    .tx_toggle_o(tx_toggle_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_last_o(tx_last_o), .tx_ready_i(tx_ready_i), .ack_i(ack_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready_i = tx_force_low ? 1'b0 : (tx_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (hs_valid_o) begin
        checks++;
        if (exp_hs.size() == 0) begin
          failures++; $display("FAIL hs_unexpected got=%h required=none", hs_pid_o);
        end else begin
          m_hs = exp_hs.pop_front();
          if (hs_pid_o !== m_hs) begin failures++; $display("FAIL hs_pid got=%h required=%h", hs_pid_o, m_hs); end
        end
      end
      if (tx_start_o) begin
        checks++;
        if (exp_tog.size() == 0) begin
          failures++; $display("FAIL tx_start_unexpected got=1 required=0");
        end else begin
          m_tog = exp_tog.pop_front();
          if (tx_toggle_o !== m_tog) begin failures++; $display("FAIL tx_toggle got=%b required=%b", tx_toggle_o, m_tog); end
        end
      end
      if (tx_valid_o) begin
        checks++;
        if (exp_tx.size() == 0) begin
          failures++; $display("FAIL tx_unexpected got=%h required=none", tx_data_o);
        end else begin
          m_tx = exp_tx[0];
          if ({tx_last_o, tx_data_o} !== m_tx) begin
            failures++; $display("FAIL tx_byte got=%b/%h required=%b/%h", tx_last_o, tx_data_o, m_tx[8], m_tx[7:0]);
          end
          if (tx_ready_i) m_tx = exp_tx.pop_front();
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_out.size() == 0) begin
          failures++; $display("FAIL out_unexpected got=%h required=none", out_data_o);
        end else begin
          m_out = exp_out.pop_front();
          if (out_data_o !== m_out) begin failures++; $display("FAIL out_byte got=%h required=%h", out_data_o, m_out); end
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_hs.size() + exp_tx.size() + exp_out.size() + exp_tog.size()) != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_%s pending hs=%0d tx=%0d out=%0d tog=%0d required=0", nm,
               exp_hs.size(), exp_tx.size(), exp_out.size(), exp_tog.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_out(input logic tog, input int n, input logic [7:0] base, input logic crc);
    @(posedge clk); #1; token_i = 1'b1; pid_i = PID_OUT;
    @(posedge clk); #1; token_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 8'(base + i);
      @(posedge clk); #1;
    end
    rx_valid_i = 1'b0; rx_end_i = 1'b1; rx_crc_ok_i = crc; rx_toggle_i = tog;
    @(posedge clk); #1; rx_end_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_out(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) exp_out.push_back(8'(base + i));
  endtask

  task automatic push_tx(input int n, input logic [7:0] base);
    exp_tog.push_back(exp_in_tog);
    for (int i = 0; i < n; i++) exp_tx.push_back({(i == n - 1), 8'(base + i)});
  endtask

  task automatic app_write(input int n, input logic [7:0] base);
    logic rdy;
    int g;
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b1; in_data_i = 8'(base + i); g = 0;
      do begin
        @(negedge clk); rdy = in_ready_o;
        @(posedge clk); #1; g++;
      end while (!rdy && g < 50);
      if (!rdy) begin
        checks++; failures++; $display("FAIL app_write_timeout in_ready=0 required=1");
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic in_token();
    @(posedge clk); #1; token_i = 1'b1; pid_i = PID_IN;
    @(posedge clk); #1; token_i = 1'b0;
  endtask

  task automatic host_ack();
    @(posedge clk); #1; ack_i = 1'b1; exp_in_tog = ~exp_in_tog;
    @(posedge clk); #1; ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; configured = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hs_valid_o, hs_pid_o, tx_start_o, tx_toggle_o, tx_valid_o, tx_last_o, tx_data_o,
         out_valid_o, out_data_o} !== '0) begin
      failures++; $display("FAIL reset_outputs got_nonzero required=0");
    end
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b required=0", in_ready_o); end
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b required=1", in_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_basic();
    exp_hs.push_back(ACK); push_out(7, 8'h01);
    send_out(exp_out_tog, 7, 8'h01, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("out_basic");
    exp_hs.push_back(ACK); push_out(2, 8'h21);
    send_out(exp_out_tog, 2, 8'h21, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("out_data1");
  endtask

  task automatic test_in_basic();
    app_write(7, 8'h01);
    push_tx(7, 8'h01); in_token(); wait_drain("in_basic");
    host_ack();
    exp_hs.push_back(NAK); in_token(); wait_drain("in_nak");
  endtask

  task automatic test_zlp();
    app_write(8, 8'h11);
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL in_full_ready got=%b required=0", in_ready_o); end
    push_tx(8, 8'h11); in_token(); wait_drain("in_full");
    host_ack();
    push_tx(0, 8'h00); in_token(); wait_drain("zlp");
    host_ack();
    exp_hs.push_back(NAK); in_token(); wait_drain("zlp_nak");
  endtask

  task automatic test_out_busy();
    out_ready_i = 1'b0;
    exp_hs.push_back(ACK); push_out(8, 8'h31);
    send_out(exp_out_tog, 8, 8'h31, 1'b1); exp_out_tog = ~exp_out_tog;
    exp_hs.push_back(NAK);
    send_out(exp_out_tog, 8, 8'h41, 1'b1);
    repeat (5) @(posedge clk);
    #1; out_ready_i = 1'b1;
    wait_drain("out_busy");
    exp_hs.push_back(ACK); push_out(8, 8'h41);
    send_out(exp_out_tog, 8, 8'h41, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("out_resend");
  endtask

  task automatic test_out_errors();
    send_out(exp_out_tog, 3, 8'h51, 1'b0);
    send_out(exp_out_tog, 9, 8'h61, 1'b1);
    wait_drain("out_bad");
    exp_hs.push_back(ACK);
    send_out(exp_out_tog, 0, 8'h00, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("out_zero");
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL out_zero_len_valid got=%b required=0", out_valid_o); end
    exp_hs.push_back(ACK); push_out(2, 8'h71);
    send_out(exp_out_tog, 2, 8'h71, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("out_after_err");
  endtask

  task automatic test_retransmit();
    tx_rand = 1'b1;
    app_write(4, 8'h81);
    push_tx(4, 8'h81); in_token(); wait_drain("in_first");
    push_tx(4, 8'h81); in_token(); wait_drain("in_retx");
    host_ack();
    tx_rand = 1'b0;
    exp_hs.push_back(ACK);
    send_out(~exp_out_tog, 3, 8'h91, 1'b1);
    wait_drain("out_dup");
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL out_dup_valid got=%b required=0", out_valid_o); end
  endtask

  task automatic test_config_drop();
    app_write(2, 8'hA1);
    push_tx(2, 8'hA1); in_token(); wait_drain("cfg_pre_in");
    host_ack();
    exp_hs.push_back(ACK); push_out(3, 8'hB1);
    send_out(exp_out_tog, 3, 8'hB1, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("cfg_pre_out");
    app_write(3, 8'hC1);
    tx_force_low = 1'b1;
    push_tx(3, 8'hC1); in_token();
    repeat (4) @(posedge clk);
    #1; configured = 1'b0;
    @(posedge clk); #1; configured = 1'b1; exp_tx.delete();
    exp_in_tog = 1'b0; exp_out_tog = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL cfg_tx_valid got=%b required=0", tx_valid_o); end
    checks++;
    if (tx_toggle_o !== 1'b0) begin failures++; $display("FAIL cfg_tx_toggle got=%b required=0", tx_toggle_o); end
    tx_force_low = 1'b0;
    exp_hs.push_back(NAK); in_token(); wait_drain("cfg_nak");
    exp_hs.push_back(ACK); push_out(2, 8'hD1);
    send_out(exp_out_tog, 2, 8'hD1, 1'b1); exp_out_tog = ~exp_out_tog;
    wait_drain("cfg_out_data0");
  endtask

  task automatic test_reset_in_data();
    app_write(2, 8'hE1);
    push_tx(2, 8'hE1); in_token(); wait_drain("rst_pre_in");
    host_ack();
    app_write(2, 8'hE5);
    tx_force_low = 1'b1;
    push_tx(2, 8'hE5); in_token();
    repeat (4) @(posedge clk);
    #1; rstn = 1'b0;
    #1;
    checks++;
    if ({tx_valid_o, tx_start_o, tx_toggle_o, in_ready_o, hs_valid_o} !== 5'b0) begin
      failures++; $display("FAIL rst_async got=%b required=00000",
                           {tx_valid_o, tx_start_o, tx_toggle_o, in_ready_o, hs_valid_o});
    end
    exp_tx.delete(); exp_tog.delete(); exp_hs.delete(); exp_out.delete();
    exp_in_tog = 1'b0; exp_out_tog = 1'b0; tx_force_low = 1'b0;
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    exp_hs.push_back(NAK); in_token(); wait_drain("rst_nak");
    app_write(1, 8'hF1);
    push_tx(1, 8'hF1); in_token(); wait_drain("rst_data0");
    host_ack();
  endtask

  initial begin
    token_i = 1'b0; pid_i = 4'h0; rx_data_i = 8'h00; rx_valid_i = 1'b0; rx_end_i = 1'b0;
    rx_crc_ok_i = 1'b0; rx_toggle_i = 1'b0; ack_i = 1'b0; out_ready_i = 1'b1;
    in_data_i = 8'h00; in_valid_i = 1'b0; rstn = 1'b0; configured = 1'b0;
    test_reset();
    test_out_basic();
    test_in_basic();
    test_zlp();
    test_out_busy();
    test_out_errors();
    test_retransmit();
    test_config_drop();
    test_reset_in_data();
    wait_drain("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
